// File: rtl/selector_campo_edicion.sv
// rtl/selector_campo_edicion.sv - button debounce, field select and step pulse controller for clock set-up
module selector_campo_edicion #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int REP_DELAY  = 50_000_000,
  parameter int REP_RATE   = 10_000_000,
  parameter int NUM_FIELDS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_edit,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       edit_mode
);

  localparam int NB       = 5;
  localparam int B_EDIT   = 0;
  localparam int B_UP     = 1;
  localparam int B_DOWN   = 2;
  localparam int B_LEFT   = 3;
  localparam int B_RIGHT  = 4;
  localparam int DW       = $clog2(DEB_CYCLES + 1);
  localparam int REP_MAX  = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW       = $clog2(REP_MAX + 1);

  typedef enum logic {ST_IDLE, ST_EDIT} state_t;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] w_deb;
  logic [NB-1:0] w_press;

  assign w_raw = {btn_right, btn_left, btn_down, btn_up, btn_edit};

  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_btn
    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_q;
    logic [DW-1:0] r_cnt;

    // Two-flop synchroniser plus a delayed copy of the debounced level for edge detection
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb_q <= 1'b0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        r_deb_q <= r_deb;
      end
    end

    // Debounced level flips only once the synchronised input has disagreed for a full run
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == DW'(DEB_CYCLES)) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[gi]   = r_deb;
    assign w_press[gi] = r_deb & ~r_deb_q;
  end

  state_t        r_state;
  logic [3:0]    r_field;
  logic          r_edit;
  logic          r_up;
  logic          r_down;
  logic          r_rep_act;
  logic          r_rep_up;
  logic          r_rep_first;
  logic [RW-1:0] r_rep_cnt;

  logic [3:0]    w_field_inc;
  logic [3:0]    w_field_dec;
  logic [RW-1:0] w_rep_limit;
  logic          w_rep_held;
  logic          w_lr;
  logic          w_both;

  assign w_field_inc = (r_field == 4'(NUM_FIELDS)) ? 4'd1 : r_field + 4'd1;
  assign w_field_dec = (r_field <= 4'd1) ? 4'(NUM_FIELDS) : r_field - 4'd1;
  assign w_rep_limit = r_rep_first ? RW'(REP_DELAY - 1) : RW'(REP_RATE - 1);
  assign w_rep_held  = r_rep_up ? w_deb[B_UP] : w_deb[B_DOWN];
  assign w_lr        = w_press[B_LEFT] | w_press[B_RIGHT];
  assign w_both      = w_deb[B_UP] & w_deb[B_DOWN];

  // Edit FSM: field selection, step pulses and auto-repeat, all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_field     <= 4'd0;
      r_edit      <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_rep_act   <= 1'b0;
      r_rep_up    <= 1'b0;
      r_rep_first <= 1'b0;
      r_rep_cnt   <= '0;
    end else begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rep_act <= 1'b0;
          r_rep_cnt <= '0;
          if (w_press[B_EDIT]) begin
            r_state <= ST_EDIT;
            r_field <= 4'd1;
            r_edit  <= 1'b1;
          end
        end
        ST_EDIT: begin
          if (w_press[B_EDIT]) begin
            r_state   <= ST_IDLE;
            r_field   <= 4'd0;
            r_edit    <= 1'b0;
            r_rep_act <= 1'b0;
            r_rep_cnt <= '0;
          end else if (w_lr) begin
            // Field moves take precedence; a coincident step would change the field under it
            r_rep_act <= 1'b0;
            r_rep_cnt <= '0;
            if (w_press[B_RIGHT] && !w_press[B_LEFT]) begin
              r_field <= w_field_inc;
            end else if (w_press[B_LEFT] && !w_press[B_RIGHT]) begin
              r_field <= w_field_dec;
            end
          end else if (w_both) begin
            r_rep_act <= 1'b0;
            r_rep_cnt <= '0;
          end else if (w_press[B_UP]) begin
            r_up        <= 1'b1;
            r_rep_act   <= 1'b1;
            r_rep_up    <= 1'b1;
            r_rep_first <= 1'b1;
            r_rep_cnt   <= '0;
          end else if (w_press[B_DOWN]) begin
            r_down      <= 1'b1;
            r_rep_act   <= 1'b1;
            r_rep_up    <= 1'b0;
            r_rep_first <= 1'b1;
            r_rep_cnt   <= '0;
          end else if (r_rep_act) begin
            if (!w_rep_held) begin
              r_rep_act <= 1'b0;
              r_rep_cnt <= '0;
            end else if (r_rep_cnt == w_rep_limit) begin
              r_up        <= r_rep_up;
              r_down      <= ~r_rep_up;
              r_rep_first <= 1'b0;
              r_rep_cnt   <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign en_count  = r_field;
  assign enUP      = r_up;
  assign enDOWN    = r_down;
  assign edit_mode = r_edit;

endmodule

// File: tb/tb_selector_campo_edicion.sv
// tb/tb_selector_campo_edicion.sv - randomized and directed bench for selector_campo_edicion
module tb_selector_campo_edicion;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int NF  = 6;
  localparam int E = 0, U = 1, D = 2, L = 3, R = 4;
  localparam int HN = 16384;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_edit = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0] en_count;
  logic       enUP, enDOWN, edit_mode;

  selector_campo_edicion #(
    .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_RATE(RR), .NUM_FIELDS(NF)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_edit(btn_edit), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN), .edit_mode(edit_mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit h_up[HN];
  bit h_down[HN];
  bit h_edit[HN];
  int h_field[HN];

  // reference model state
  bit          m_edit, m_up, m_down, m_rep, m_rep_up;
  int          m_field, m_due;
  bit          dm[5], dmp[5];
  logic [15:0] rh[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edit = 0; m_up = 0; m_down = 0; m_rep = 0; m_rep_up = 0;
    m_field = 0; m_due = 0;
    for (int b = 0; b < 5; b++) begin
      dm[b] = 0; dmp[b] = 0; rh[b] = '0;
    end
  endtask

  // One clock edge k: decisions use debounced levels from before the edge
  task automatic model_step(input int k);
    bit p[5];
    logic [4:0] rv;
    bit diff;
    rv = {btn_right, btn_left, btn_down, btn_up, btn_edit};
    for (int b = 0; b < 5; b++) p[b] = dm[b] & ~dmp[b];
    m_up = 0; m_down = 0;
    if (!m_edit) begin
      m_rep = 0;
      if (p[E]) begin m_edit = 1; m_field = 1; end
    end else if (p[E]) begin
      m_edit = 0; m_field = 0; m_rep = 0;
    end else if (p[L] || p[R]) begin
      m_rep = 0;
      if (p[R] && !p[L]) m_field = m_field % NF + 1;
      else if (p[L] && !p[R]) m_field = (m_field + NF - 2) % NF + 1;
    end else if (dm[U] && dm[D]) begin
      m_rep = 0;
    end else if (p[U]) begin
      m_up = 1; m_rep = 1; m_rep_up = 1; m_due = k + RD;
    end else if (p[D]) begin
      m_down = 1; m_rep = 1; m_rep_up = 0; m_due = k + RD;
    end else if (m_rep) begin
      if (!(m_rep_up ? dm[U] : dm[D])) m_rep = 0;
      else if (k == m_due) begin
        if (m_rep_up) m_up = 1; else m_down = 1;
        m_due = k + RR;
      end
    end
    // raw sampled at edge k enters bit 0; the debouncer sees it two edges later
    for (int b = 0; b < 5; b++) begin
      rh[b] = {rh[b][14:0], rv[b]};
      dmp[b] = dm[b];
      diff = 1;
      for (int j = 2; j <= 2 + DEB; j++) if (rh[b][j] == dm[b]) diff = 0;
      if (diff) dm[b] = ~dm[b];
    end
  endtask

  // compare process
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) model_reset();
      else model_step(cyc);
      #1;
      if (cyc < HN) begin
        h_up[cyc] = enUP; h_down[cyc] = enDOWN; h_edit[cyc] = edit_mode; h_field[cyc] = int'(en_count);
      end
      chk("edit_mode", int'(edit_mode), int'(m_edit));
      chk("en_count", int'(en_count), m_field);
      chk("enUP", int'(enUP), int'(m_up));
      chk("enDOWN", int'(enDOWN), int'(m_down));
    end
  end

  task automatic set_btn(input logic [4:0] m);
    btn_edit = m[0]; btn_up = m[1]; btn_down = m[2]; btn_left = m[3]; btn_right = m[4];
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m, input int hold, input int gap, output int t0);
    @(negedge clk);
    set_btn(m);
    t0 = cyc + 1;
    wait_cyc(hold);
    set_btn(5'b0);
    wait_cyc(gap);
  endtask

  function automatic int count_sig(input int which, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) begin
      if (which == 0) n += int'(h_up[i]);
      else if (which == 1) n += int'(h_down[i]);
      else n += int'(h_edit[i]);
    end
    return n;
  endfunction

  initial begin
    int t, n, bad, hold, gap, prev;
    logic [4:0] m;
    int exp_r[6];
    int exp_pos[5];
    exp_r = '{2, 3, 4, 5, 6, 1};
    exp_pos = '{7, 27, 32, 37, 42};

    set_btn(5'b0);
    reset = 1'b0;
    wait_cyc(3);
    chk("rst_edit_mode", int'(edit_mode), 0);
    chk("rst_en_count", int'(en_count), 0);
    chk("rst_enUP", int'(enUP), 0);
    chk("rst_enDOWN", int'(enDOWN), 0);
    reset = 1'b1;
    wait_cyc(2);

    // enter and leave EDIT
    press(5'b00001, 10, 12, t);
    chk("edit_before", int'(h_edit[t+6]), 0);
    chk("edit_on", int'(h_edit[t+7]), 1);
    chk("field_on", h_field[t+7], 1);
    press(5'b00001, 10, 12, t);
    chk("edit_still", int'(h_edit[t+6]), 1);
    chk("edit_off", int'(h_edit[t+7]), 0);
    chk("field_off", h_field[t+7], 0);

    // glitch in EDIT, then up in IDLE
    press(5'b00001, 10, 12, t);
    press(5'b00010, 3, 12, t);
    chk("glitch_up", count_sig(0, t, t + 14), 0);
    press(5'b00001, 10, 12, t);
    press(5'b00010, 10, 14, t);
    chk("idle_up", count_sig(0, t, t + 23), 0);

    // field stepping
    press(5'b00001, 10, 12, t);
    prev = 1;
    for (int i = 0; i < 6; i++) begin
      press(5'b10000, 10, 12, t);
      chk("right_hold", h_field[t+6], prev);
      chk("right_step", h_field[t+7], exp_r[i]);
      prev = exp_r[i];
    end
    press(5'b01000, 10, 12, t);
    chk("left_wrap", h_field[t+7], 6);
    press(5'b01000, 10, 12, t);
    press(5'b01000, 10, 12, t);
    chk("left_to4", h_field[t+7], 4);

    // auto-repeat on field 4
    press(5'b00010, 40, 20, t);
    n = 0;
    bad = 0;
    for (int i = t; i < t + 60; i++) begin
      if (h_up[i]) begin
        if (n < 5) chk("rep_pos", i - t, exp_pos[n]);
        n++;
      end
      if (h_field[i] != 4) bad++;
    end
    chk("rep_count", n, 5);
    chk("rep_field", bad, 0);
    chk("rep_down", count_sig(1, t, t + 59), 0);

    // conflicts
    press(5'b00110, 60, 12, t);
    chk("both_up", count_sig(0, t, t + 71), 0);
    chk("both_down", count_sig(1, t, t + 71), 0);
    press(5'b10010, 10, 12, t);
    chk("ru_field", h_field[t+7], 5);
    chk("ru_up", count_sig(0, t, t + 21), 0);

    // reset in the middle of a held down
    @(negedge clk);
    set_btn(5'b00100);
    t = cyc + 1;
    wait_cyc(31);
    chk("pre_rst_edit", int'(h_edit[t+30]), 1);
    chk("pre_rst_down_rep", int'(h_down[t+27]), 1);
    reset = 1'b0;
    #1;
    chk("async_edit_mode", int'(edit_mode), 0);
    chk("async_en_count", int'(en_count), 0);
    chk("async_enUP", int'(enUP), 0);
    chk("async_enDOWN", int'(enDOWN), 0);
    set_btn(5'b0);
    wait_cyc(3);
    reset = 1'b1;
    t = cyc + 1;
    wait_cyc(50);
    chk("post_rst_pulses", count_sig(0, t, t + 49) + count_sig(1, t, t + 49), 0);
    chk("post_rst_idle", count_sig(2, t, t + 49), 0);

    // randomized traffic checked by the model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) < 7) m = 5'b00001 << $urandom_range(0, 4);
      else m = 5'($urandom);
      hold = $urandom_range(1, 35);
      gap = $urandom_range(1, 15);
      press(m, hold, gap, t);
    end

    wait_cyc(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
